elastic_pipeline: RTL and testbench
===================================

// Module: elastic_pipeline
// PURPOSE
//   Parametrised multi-stage register pipeline with per-stage valid bits and
//   valid/ready backpressure. Successor to the fixed-delay pipeline: adds
//   handshaking, bubble collapsing, stall propagation and synchronous flush.
//   Used between DSP stages of the autotune datapath, where downstream blocks
//   (pitch detect, resampler) stall intermittently.
// PARAMETERS
//   STAGES  4   number of register stages; must be >= 1 (elaboration $error otherwise)
//   WIDTH   32  data width in bits
// PORTS
//   clk         in   1           clock, all logic on posedge
//   rst_n       in   1           asynchronous active-low reset
//   flush       in   1           synchronous clear of all stages
//   din         in   WIDTH       input data
//   din_valid   in   1           input beat present
//   din_ready   out  1           pipeline accepts din this cycle
//   dout        out  WIDTH       output data (= last stage register)
//   dout_valid  out  1           output beat present
//   dout_ready  in   1           downstream accepts dout this cycle
//   occupancy   out  $clog2(STAGES+1)  valid stages (ELASTIC_PIPE_STATS_EN only)
//   stall_cnt   out  16          stall cycles, saturating (ELASTIC_PIPE_STATS_EN only)
// BEHAVIOUR
//   - Reset (rst_n=0, async): all stage valid bits 0, all data regs 0;
//     dout=0, dout_valid=0; stats counters 0. din_ready=0 while in reset.
//   - Stage i holds data_i, v_i. Stage STAGES-1 drives dout/dout_valid.
//   - Advance chain (combinational, from output back):
//     rdy_{STAGES} = dout_ready; rdy_i = !v_i || rdy_{i+1}; din_ready = rdy_0 & !flush.
//   - Stage i loads when rdy_i: data_i <= previous stage data, v_i <= previous valid
//     (stage 0 takes din, din_valid & !flush). data_i unchanged when !rdy_i.
//   - Transfer in: din_valid & din_ready. Transfer out: dout_valid & dout_ready.
//   - Latency: exactly STAGES cycles din->dout with dout_ready held 1; throughput 1/cycle.
//   - Bubble collapse: an empty stage always accepts, so gaps are squeezed out while
//     the output stalls; up to STAGES beats buffered under full stall.
//   - Full: all v_i=1 and dout_ready=0 -> din_ready=0; nothing moves; dout stable.
//   - Full with dout_ready=1: output and input transfer in the same cycle, no bubble.
//   - Valid-stable rule: once dout_valid=1, dout and dout_valid hold until dout_ready=1
//     (AXI-stream style); upstream must likewise hold din while din_valid & !din_ready.
//   - flush=1: on next edge all v_i <= 0; din not accepted that cycle (din_ready=0);
//     a dout transfer in the flush cycle still counts as delivered. Data regs untouched.
//   - Async reset mid-stream: in-flight beats dropped immediately, no partial output.
//   - Order preserved; no beat duplicated or dropped except by flush/reset.
// CONFIGURATION
//   ELASTIC_PIPE_STATS_EN defined:
//     occupancy = popcount(v_0..v_{STAGES-1}), registered, updated each cycle,
//       0 after flush/reset.
//     stall_cnt +1 each cycle dout_valid & !dout_ready, saturates at 16'hFFFF;
//       cleared by reset and flush.
//   Not defined: occupancy and stall_cnt ports absent; no counter logic.
// TESTING
//   1. STAGES=4, dout_ready=1, push 0x10..0x1F back-to-back -> dout 0x10 first at
//      cycle 4 after first accept, then one beat/cycle, in order.
//   2. dout_ready=0, push 6 beats -> exactly 4 accepted, din_ready=0 after 4th;
//      raise dout_ready -> 4 beats out in order, then remaining 2 accepted.
//   3. din_valid alternating 1/0 with dout_ready=0 for 8 cycles -> bubbles collapse,
//      4 beats buffered, occupancy=4, stall_cnt counts from first dout_valid.
//   4. Pipeline holding 3 beats, assert flush 1 cycle with din_valid=1 -> dout_valid=0
//      next cycle, din not accepted, occupancy=0, stall_cnt=0.
//   5. Full pipe, dout_ready=1 and din_valid=1 same cycle -> one in, one out,
//      occupancy stays 4.
//   6. Pull rst_n low mid-stream between edges -> dout_valid, dout 0 immediately;
//      after release first new beat emerges after STAGES cycles.

Source files
------------

// File: rtl/elastic_pipeline.sv
// ---------------------------------------------------------------------------
// elastic_pipeline
//   Multi-stage register pipeline with per-stage valid bits and valid/ready
//   backpressure. Empty stages always accept, so bubbles collapse while the
//   output is stalled and up to STAGES beats can be buffered. A synchronous
//   flush drops every in-flight beat but leaves the data registers untouched.
//
// Parameters
//   STAGES      number of register stages (>= 1)
//   WIDTH       data width in bits
//
// Ports
//   clk         clock, all logic on posedge
//   rst_n       asynchronous active-low reset
//   flush       synchronous clear of all stage valid bits
//   din         input data
//   din_valid   input beat present
//   din_ready   pipeline accepts din this cycle
//   dout        output data (last stage register)
//   dout_valid  output beat present
//   dout_ready  downstream accepts dout this cycle
//   occupancy   number of valid stages, registered   (ELASTIC_PIPE_STATS_EN)
//   stall_cnt   saturating count of output stall cycles (ELASTIC_PIPE_STATS_EN)
//
// Define ELASTIC_PIPE_STATS_EN to add the occupancy/stall_cnt ports and counters.
// ---------------------------------------------------------------------------
module elastic_pipeline #(
  parameter int unsigned STAGES = 4,
  parameter int unsigned WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             din,
  input  logic                         din_valid,
  output logic                         din_ready,
  output logic [WIDTH-1:0]             dout,
  output logic                         dout_valid,
  input  logic                         dout_ready
`ifdef ELASTIC_PIPE_STATS_EN
  ,
  output logic [$clog2(STAGES+1)-1:0]  occupancy,
  output logic [15:0]                  stall_cnt
`endif
);

  if (STAGES < 1) begin : g_bad_cfg
    $error("elastic_pipeline: STAGES must be >= 1");
  end

  // rdy[i] is the advance enable of stage i; rdy[STAGES] is the downstream ready.
  logic [STAGES:0]  rdy;
  // chain_*[i] is the input of stage i; chain_*[STAGES] is the pipeline output.
  logic [STAGES:0]  chain_v;
  logic [WIDTH-1:0] chain_d [STAGES+1];

`ifdef ELASTIC_PIPE_STATS_EN
  logic [STAGES-1:0] v_next;
`endif

  assign rdy[STAGES] = dout_ready;
  assign chain_v[0]  = din_valid;
  assign chain_d[0]  = din;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic             v_q;
    logic             v_d;
    logic [WIDTH-1:0] d_q;

    // A stage can take a new beat if it is empty or its own beat moves on.
    assign rdy[i] = !v_q || rdy[i+1];

    always_comb begin
      v_d = v_q;
      if (flush) begin
        v_d = 1'b0;
      end else if (rdy[i]) begin
        v_d = chain_v[i];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else begin
        v_q <= v_d;
        // Flush only clears valid bits; data registers keep their contents.
        if (rdy[i] && !flush) begin
          d_q <= chain_d[i];
        end
      end
    end

    assign chain_v[i+1] = v_q;
    assign chain_d[i+1] = d_q;

`ifdef ELASTIC_PIPE_STATS_EN
    assign v_next[i] = v_d;
`endif
  end

  // Hold off upstream during reset and during a flush cycle.
  assign din_ready  = rdy[0] && !flush && rst_n;
  assign dout       = chain_d[STAGES];
  assign dout_valid = chain_v[STAGES];

`ifdef ELASTIC_PIPE_STATS_EN
  localparam int unsigned OccW = $clog2(STAGES+1);

  // Registered from the next-state valid bits so it tracks the current stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
      stall_cnt <= '0;
    end else begin
      occupancy <= OccW'($countones(v_next));
      if (flush) begin
        stall_cnt <= '0;
      end else if (dout_valid && !dout_ready && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_elastic_pipeline.sv
`timescale 1ns/1ps
module tb_elastic_pipeline;
  localparam int STAGES = 4;
  localparam int WIDTH  = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             din_valid = 1'b0;
  logic             din_ready;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready = 1'b0;
`ifdef ELASTIC_PIPE_STATS_EN
  logic [$clog2(STAGES+1)-1:0] occupancy;
  logic [15:0]                 stall_cnt;
`endif

  elastic_pipeline #(.STAGES(STAGES), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
`ifdef ELASTIC_PIPE_STATS_EN
    ,
    .occupancy  (occupancy),
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_in     = 0;
  int n_out    = 0;
  logic [WIDTH-1:0] exp_q [$];

  typedef struct {
    logic             dv;
    logic [WIDTH-1:0] d;
    logic             dr;
    logic             e_rdy;
    logic             e_vld;
    logic [WIDTH-1:0] e_dout;
  } vec_t;
  vec_t tab [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: inputs pushed on accept, compared in order on delivery.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dout_valid && dout_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: got beat 0x%0h expected none", dout);
        end else begin
          check("sb_data", dout, exp_q.pop_front());
        end
      end
      if (flush) exp_q.delete();
      if (din_valid && din_ready) begin
        exp_q.push_back(din);
        n_in++;
      end
    end
  end

  // Drive inputs just after posedge, return at the following negedge.
  task automatic step(input logic dv, input logic [WIDTH-1:0] d, input logic dr,
                      input logic fl);
    @(posedge clk);
    #1;
    din_valid  = dv;
    din        = d;
    dout_ready = dr;
    flush      = fl;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    din_valid = 1'b0;
    dout_ready = 1'b0;
    flush = 1'b0;
    exp_q.delete();
    n_in = 0;
    n_out = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_out;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_din_ready", din_ready, 1'b0);
    check("rst_dout_valid", dout_valid, 1'b0);
    check("rst_dout", dout, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rel_din_ready", din_ready, 1'b1);
`ifdef ELASTIC_PIPE_STATS_EN
    check("rst_occupancy", occupancy, 0);
    check("rst_stall_cnt", stall_cnt, 0);
`endif

    // 1: back-to-back stream with dout_ready held, latency and order
    first_out = -1;
    for (int s = 0; s < 24; s++) begin
      if (s < 16) step(1'b1, 32'h10 + s, 1'b1, 1'b0);
      else        step(1'b0, 32'h0, 1'b1, 1'b0);
      if (s < 16) check("t1_din_ready", din_ready, 1'b1);
      if (dout_valid && first_out < 0) first_out = s;
    end
    check("t1_latency", first_out, STAGES);
    check("t1_beats_out", n_out, 16);

    // 2: full-stall table, then release
    do_reset();
    for (int k = 0; k < 6; k++)
      tab[k] = '{1'b1, 32'hA0 + (k < 4 ? k : 4), 1'b0, k < 4, k >= 4, 32'hA0};
    tab[6]  = '{1'b1, 32'hA4, 1'b1, 1'b1, 1'b1, 32'hA0};
    tab[7]  = '{1'b1, 32'hA5, 1'b1, 1'b1, 1'b1, 32'hA1};
    for (int k = 8; k < 12; k++) tab[k] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hA0 + k - 6};
    tab[12] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0};
    for (int k = 0; k < 13; k++) begin
      step(tab[k].dv, tab[k].d, tab[k].dr, 1'b0);
      check($sformatf("t2_din_ready[%0d]", k), din_ready, tab[k].e_rdy);
      check($sformatf("t2_dout_valid[%0d]", k), dout_valid, tab[k].e_vld);
      if (tab[k].e_vld) check($sformatf("t2_dout[%0d]", k), dout, tab[k].e_dout);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("t2_beats_in", n_in, 6);
    check("t2_beats_out", n_out, 6);

    // 3: alternating input under stall collapses bubbles
    do_reset();
    for (int c = 0; c < 8; c++) step(c % 2 == 0, 32'hB0 + c, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    check("t3_beats_in", n_in, 4);
    check("t3_din_ready", din_ready, 1'b0);
    check("t3_dout_valid", dout_valid, 1'b1);
    check("t3_dout", dout, 32'hB0);
`ifdef ELASTIC_PIPE_STATS_EN
    check("t3_occupancy", occupancy, 4);
    check("t3_stall_cnt", stall_cnt, 4);
`endif
    for (int c = 0; c < 6; c++) step(1'b0, 32'h0, 1'b1, 1'b0);
    check("t3_beats_out", n_out, 4);

    // 4: flush with three beats held
    do_reset();
    for (int c = 0; c < 3; c++) step(1'b1, 32'hC0 + c, 1'b0, 1'b0);
    for (int c = 0; c < 2; c++) step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'hCC, 1'b0, 1'b1);
    check("t4_flush_din_ready", din_ready, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    check("t4_dout_valid", dout_valid, 1'b0);
`ifdef ELASTIC_PIPE_STATS_EN
    check("t4_occupancy", occupancy, 0);
    check("t4_stall_cnt", stall_cnt, 0);
`endif
    for (int c = 0; c < 6; c++) step(1'b0, 32'h0, 1'b1, 1'b0);
    check("t4_beats_in", n_in, 3);
    check("t4_beats_out", n_out, 0);

    // 5: full pipe, simultaneous in and out
    do_reset();
    for (int c = 0; c < 4; c++) step(1'b1, 32'hD0 + c, 1'b0, 1'b0);
    step(1'b1, 32'hD4, 1'b1, 1'b0);
    check("t5_din_ready", din_ready, 1'b1);
    check("t5_dout", dout, 32'hD0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    check("t5_dout_next", dout, 32'hD1);
    check("t5_full_din_ready", din_ready, 1'b0);
`ifdef ELASTIC_PIPE_STATS_EN
    check("t5_occupancy", occupancy, 4);
`endif
    for (int c = 0; c < 6; c++) step(1'b0, 32'h0, 1'b1, 1'b0);
    check("t5_beats_out", n_out, 5);

    // 6: asynchronous reset mid-stream
    do_reset();
    for (int c = 0; c < 5; c++) step(1'b1, 32'hE0 + c, 1'b1, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_dout_valid", dout_valid, 1'b0);
    check("t6_dout", dout, 32'h0);
    check("t6_din_ready", din_ready, 1'b0);
    din_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    n_in = 0;
    n_out = 0;
    step(1'b1, 32'hF0, 1'b1, 1'b0);
    check("t6_accept", din_ready, 1'b1);
    first_out = -1;
    for (int c = 1; c <= 10 && first_out < 0; c++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      if (dout_valid) first_out = c;
    end
    check("t6_latency", first_out, STAGES);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("t6_beats_out", n_out, 1);
    check("end_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
